conjugate_result_writeback: RTL and testbench
=============================================

Name: conjugate_result_writeback

Overview:
Downstream writeback stage for the conjugate vector-times-constant-add datapath. It captures each NO_OF_UNITS-wide result row presented with a write strobe and buffers it in a small FIFO. It then writes the rows to consecutive addresses of the result memory, honouring the memory's ready handshake, and asserts finish once all expected rows are stored.

Parameters:
ELEMENT_WIDTH, 64, width of one complex element (upper half imag, lower half real)
NO_OF_UNITS, 8, elements per row
ADDR_WIDTH, 10, result memory address width (row granularity)
FIFO_DEPTH, 4, row buffer depth (power of two, >=2)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse; latches base_addr/total, begins a job
base_addr  in  ADDR_WIDTH  first row address of the job
total  in  32  element count; rows = total / NO_OF_UNITS (floor)
in_data  in  ELEMENT_WIDTH*NO_OF_UNITS  result row from the vXc add unit
in_valid  in  1  row strobe (driven by the upstream result_mem_we)
in_ready  out  1  FIFO can accept this cycle (advisory; producer is free-running)
mem_we  out  1  write request
mem_addr  out  ADDR_WIDTH  write address
mem_wdata  out  ELEMENT_WIDTH*NO_OF_UNITS  write data
mem_ready  in  1  memory accepts; write occurs when mem_we && mem_ready
busy  out  1  job in progress
finish  out  1  all rows written; held high
overflow  out  1  sticky: row arrived while FIFO full
rows_written  out  32  rows committed in current job

Behaviour:
- Reset (also mid-job): state IDLE, FIFO emptied, all counters 0. Outputs: mem_we=0, finish=0, busy=0, overflow=0, in_ready=0, rows_written=0. mem_addr and mem_wdata = 0.
- FSM states:
  - IDLE: waits for start. On start, latch rows=total/NO_OF_UNITS and base_addr, clear counters, finish and overflow; go to RUN. If rows==0, go directly to DONE.
  - RUN: accepts rows. When accepted==rows, go to DRAIN.
  - DRAIN: accepts no input. When written==rows, go to DONE.
  - DONE: finish=1, busy=0; held until the next start (which re-enters RUN or DONE as in IDLE) or reset.
- busy=1 in RUN and DRAIN. start while busy is ignored.
- Push: in RUN with in_valid, when (count<FIFO_DEPTH or a pop occurs in the same cycle) and accepted<rows; accepted increments.
- in_valid while full with no pop: row dropped, overflow=1 sticky, accepted not incremented.
- in_valid outside RUN, or after accepted==rows: ignored, no overflow.
- in_ready = RUN && accepted<rows && (count<FIFO_DEPTH || pop).
- Write side: mem_we = FIFO non-empty; mem_wdata = FIFO head; mem_addr = base + written, modulo 2^ADDR_WIDTH (wraps silently).
- mem_addr and mem_wdata are held stable while mem_we && !mem_ready.
- Pop on mem_we && mem_ready; written and rows_written increment.
- Latency: in_valid at edge N into an empty FIFO gives mem_we high in cycle N+1. Throughput is 1 row/cycle with mem_ready held high.
- Simultaneous push and pop: count unchanged, ordering preserved.
- FIFO pointers wrap modulo FIFO_DEPTH.

Optional Feature:
CONJ_WB_CHECKSUM_EN
- Defined: adds output row_checksum[ELEMENT_WIDTH-1:0], cleared on start and reset.
- On each committed write it XORs in all NO_OF_UNITS elements of mem_wdata.
- The value is stable once finish=1.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- base_addr=0x010, total=32, start; 4 rows on consecutive cycles, mem_ready=1 -> writes at 0x010..0x013 in order, mem_we first high 1 cycle after first in_valid, finish=1 after the 4th write, rows_written=4, overflow=0.
- total=5 (rows=0), start -> DONE next cycle, finish=1, mem_we never asserted.
- mem_ready=0 for 10 cycles, 6 rows pushed, FIFO_DEPTH=4 -> rows 5 and 6 dropped, overflow=1. With mem_ready then high, only 4 writes occur and the job stays in RUN awaiting 2 more rows.
- base_addr=0x3FE, total=32 -> addresses 0x3FE, 0x3FF, 0x000, 0x001.
- Reset asserted mid-DRAIN with 2 rows buffered -> next cycle mem_we=0, busy=0, finish=0, rows_written=0; subsequent start runs a clean job.
- With CONJ_WB_CHECKSUM_EN, 2 rows whose elements are all 0x1 and all 0x3 -> row_checksum=0x0 (8 identical XORs cancel per row). With one row element0=0xA5 and the rest 0 -> row_checksum=0xA5.

Source files
------------

// File: rtl/conjugate_result_writeback.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | conjugate_result_writeback: buffers vXc result rows in a FIFO and writes   |
// | them to consecutive result-memory rows. Option: CONJ_WB_CHECKSUM_EN.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module conjugate_result_writeback #(
  parameter int ELEMENT_WIDTH = 64,
  parameter int NO_OF_UNITS   = 8,
  parameter int ADDR_WIDTH    = 10,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [ADDR_WIDTH-1:0]                base_addr,
  input  logic [31:0]                          total,
  input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] in_data,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic                                 mem_we,
  output logic [ADDR_WIDTH-1:0]                mem_addr,
  output logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] mem_wdata,
  input  logic                                 mem_ready,
  output logic                                 busy,
  output logic                                 finish,
  output logic                                 overflow,
  output logic [31:0]                          rows_written
`ifdef CONJ_WB_CHECKSUM_EN
  ,
  output logic [ELEMENT_WIDTH-1:0]             row_checksum
`endif
);

  localparam int ROW_W = ELEMENT_WIDTH * NO_OF_UNITS;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [31:0]           rows_q, rows_d;
  logic [31:0]           accepted_q, accepted_d;
  logic [31:0]           written_q, written_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  finish_q, finish_d;
  logic                  overflow_q, overflow_d;
  logic [ROW_W-1:0]      fifo_q [FIFO_DEPTH];

  logic                  start_ok;
  logic                  pop;
  logic                  can_take;
  logic                  push;
  logic [31:0]           job_rows;

  always_comb begin
    start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    pop      = (count_q != '0) && mem_ready;
    can_take = (state_q == ST_RUN) && in_valid && (accepted_q < rows_q);
    // A full FIFO still takes a row when the head leaves in the same cycle.
    push     = can_take && ((count_q != DEPTH_C) || pop);
    job_rows = total / 32'(NO_OF_UNITS);

    state_d    = state_q;
    rows_d     = rows_q;
    accepted_d = accepted_q;
    written_d  = written_q;
    base_d     = base_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    finish_d   = finish_q;
    overflow_d = overflow_q;

    if (push) begin
      wr_ptr_d   = wr_ptr_q + 1'b1;
      accepted_d = accepted_q + 32'd1;
    end
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      written_d = written_q + 32'd1;
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
    if (can_take && !push) begin
      overflow_d = 1'b1;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_ok) begin
          rows_d     = job_rows;
          base_d     = base_addr;
          accepted_d = '0;
          written_d  = '0;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          count_d    = '0;
          overflow_d = 1'b0;
          finish_d   = (job_rows == '0);
          state_d    = (job_rows == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (accepted_d == rows_q) begin
          finish_d = (written_d == rows_q);
          state_d  = (written_d == rows_q) ? ST_DONE : ST_DRAIN;
        end
      end
      default: begin
        if (written_d == rows_q) begin
          finish_d = 1'b1;
          state_d  = ST_DONE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rows_q     <= '0;
      accepted_q <= '0;
      written_q  <= '0;
      base_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      finish_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rows_q     <= rows_d;
      accepted_q <= accepted_d;
      written_q  <= written_d;
      base_q     <= base_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      finish_q   <= finish_d;
      overflow_q <= overflow_d;
    end
  end

  // Row storage needs no reset; the read port is gated by the occupancy count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= in_data;
    end
  end

  assign mem_we       = (count_q != '0);
  assign mem_wdata    = mem_we ? fifo_q[rd_ptr_q] : '0;
  assign mem_addr     = base_q + written_q[ADDR_WIDTH-1:0];
  assign busy         = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign finish       = finish_q;
  assign overflow     = overflow_q;
  assign rows_written = written_q;
  assign in_ready     = (state_q == ST_RUN) && (accepted_q < rows_q) &&
                        ((count_q != DEPTH_C) || pop);

`ifdef CONJ_WB_CHECKSUM_EN
  logic [ELEMENT_WIDTH-1:0] csum_q, csum_d;
  logic [ELEMENT_WIDTH-1:0] fold;

  always_comb begin
    fold = '0;
    for (int i = 0; i < NO_OF_UNITS; i++) begin
      fold = fold ^ mem_wdata[i*ELEMENT_WIDTH +: ELEMENT_WIDTH];
    end
    csum_d = csum_q;
    if (start_ok) begin
      csum_d = '0;
    end else if (pop) begin
      csum_d = csum_q ^ fold;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign row_checksum = csum_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_conjugate_result_writeback.sv
`default_nettype none
// Randomized bench for conjugate_result_writeback with a queue-based reference
// model checked every cycle, plus directed cases with literal expectations.
module tb_conjugate_result_writeback;

  localparam int EW    = 64;
  localparam int NU    = 8;
  localparam int AW    = 10;
  localparam int DEPTH = 4;
  localparam int RW    = EW * NU;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [31:0]   total = '0;
  logic [RW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [RW-1:0] mem_wdata;
  logic          mem_ready = 1'b1;
  logic          busy;
  logic          finish;
  logic          overflow;
  logic [31:0]   rows_written;
`ifdef CONJ_WB_CHECKSUM_EN
  logic [EW-1:0] row_checksum;
`endif

  conjugate_result_writeback #(
    .ELEMENT_WIDTH(EW), .NO_OF_UNITS(NU), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .total(total),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .busy(busy), .finish(finish), .overflow(overflow), .rows_written(rows_written)
`ifdef CONJ_WB_CHECKSUM_EN
    , .row_checksum(row_checksum)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: a job is either running or not; the buffer is a queue.
  logic [RW-1:0] m_q[$];
  bit            m_run = 0, m_done = 0, m_ovf = 0, m_en = 0;
  int unsigned   m_rows = 0, m_acc = 0, m_wr = 0;
  logic [AW-1:0] m_base = '0;
  logic [EW-1:0] m_csum = '0;
  logic [AW-1:0] wlog[$];

  function automatic logic [EW-1:0] fold_row(input logic [RW-1:0] r);
    logic [EW-1:0] f = '0;
    for (int j = 0; j < NU; j++) f ^= r[j*EW +: EW];
    return f;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_q.delete();
      m_run = 0; m_done = 0; m_ovf = 0; m_rows = 0; m_acc = 0; m_wr = 0;
      m_base = '0; m_csum = '0; m_en = 1;
    end else if (m_run) begin
      bit pop_now, push_now;
      pop_now  = (m_q.size() > 0) && mem_ready;
      push_now = 0;
      if (in_valid && m_acc < m_rows) begin
        if (m_q.size() < DEPTH || pop_now) push_now = 1;
        else m_ovf = 1;
      end
      if (pop_now) begin
        m_csum ^= fold_row(m_q[0]);
        void'(m_q.pop_front());
        m_wr++;
      end
      if (push_now) begin
        m_q.push_back(in_data);
        m_acc++;
      end
      if (m_acc == m_rows && m_wr == m_rows) begin
        m_run = 0; m_done = 1;
      end
    end else if (start) begin
      m_rows = total / NU; m_base = base_addr; m_acc = 0; m_wr = 0;
      m_ovf = 0; m_csum = '0; m_q.delete();
      m_done = (m_rows == 0); m_run = (m_rows != 0);
    end
  end

  // Single compare process; also logs the addresses of committed writes.
  always @(negedge clk) begin
    if (m_en) begin
      logic exp_ready;
      exp_ready = m_run && (m_acc < m_rows) &&
                  ((m_q.size() < DEPTH) || (m_q.size() != 0 && mem_ready));
      chk("mem_we", RW'(mem_we), RW'(m_q.size() != 0));
      chk("mem_wdata", mem_wdata, (m_q.size() != 0) ? m_q[0] : '0);
      chk("mem_addr", RW'(mem_addr), RW'(AW'(m_base + m_wr)));
      chk("busy", RW'(busy), RW'(m_run));
      chk("finish", RW'(finish), RW'(m_done));
      chk("overflow", RW'(overflow), RW'(m_ovf));
      chk("rows_written", RW'(rows_written), RW'(m_wr));
      chk("in_ready", RW'(in_ready), RW'(exp_ready));
`ifdef CONJ_WB_CHECKSUM_EN
      chk("row_checksum", RW'(row_checksum), RW'(m_csum));
`endif
      if (mem_we && mem_ready && !reset) wlog.push_back(mem_addr);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [RW-1:0] rand_row();
    logic [RW-1:0] r;
    for (int k = 0; k < RW / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [RW-1:0] fill_row(input logic [EW-1:0] v);
    logic [RW-1:0] r;
    for (int k = 0; k < NU; k++) r[k*EW +: EW] = v;
    return r;
  endfunction

  task automatic start_job(input logic [AW-1:0] b, input logic [31:0] t);
    start = 1'b1; base_addr = b; total = t;
    step();
    start = 1'b0;
  endtask

  task automatic push_row(input logic [RW-1:0] r);
    in_valid = 1'b1; in_data = r;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_finish(input string name);
    for (int i = 0; i < 60 && !finish; i++) step();
    chk(name, RW'(finish), RW'(1'b1));
  endtask

  initial begin
    logic [RW-1:0] r;
    repeat (3) step();
    reset = 1'b0;
    chk("reset_mem_we", RW'(mem_we), '0);
    chk("reset_rows_written", RW'(rows_written), '0);

    // Basic job: 4 rows, consecutive addresses from 0x010.
    mem_ready = 1'b1;
    start_job(10'h010, 32);
    wlog.delete();
    in_valid = 1'b1; in_data = rand_row();
    step();
    chk("t1_latency_we", RW'(mem_we), RW'(1'b1));
    for (int i = 0; i < 3; i++) begin in_data = rand_row(); step(); end
    in_valid = 1'b0;
    wait_finish("t1_finish");
    chk("t1_nwrites", RW'(wlog.size()), RW'(4));
    for (int i = 0; i < 4 && i < wlog.size(); i++)
      chk("t1_addr", RW'(wlog[i]), RW'(10'h010 + i));
    chk("t1_rows_written", RW'(rows_written), RW'(4));
    chk("t1_overflow", RW'(overflow), '0);

    // Zero-row job finishes immediately.
    wlog.delete();
    start_job(10'h100, 5);
    chk("t2_finish", RW'(finish), RW'(1'b1));
    chk("t2_busy", RW'(busy), '0);
    repeat (3) step();
    chk("t2_no_writes", RW'(wlog.size()), '0);

    // Overflow: 6 rows into a stalled memory, only 4 survive.
    start_job(10'h000, 48);
    mem_ready = 1'b0;
    for (int i = 0; i < 6; i++) push_row(rand_row());
    repeat (4) step();
    chk("t3_overflow", RW'(overflow), RW'(1'b1));
    chk("t3_rows_written0", RW'(rows_written), '0);
    wlog.delete();
    mem_ready = 1'b1;
    repeat (8) step();
    chk("t3_nwrites", RW'(wlog.size()), RW'(4));
    chk("t3_rows_written4", RW'(rows_written), RW'(4));
    chk("t3_still_busy", RW'(busy), RW'(1'b1));
    chk("t3_no_finish", RW'(finish), '0);
    push_row(rand_row());
    push_row(rand_row());
    wait_finish("t3_finish");
    chk("t3_rows_written6", RW'(rows_written), RW'(6));

    // Address wrap.
    wlog.delete();
    start_job(10'h3FE, 32);
    for (int i = 0; i < 4; i++) push_row(rand_row());
    wait_finish("t4_finish");
    chk("t4_nwrites", RW'(wlog.size()), RW'(4));
    if (wlog.size() == 4) begin
      chk("t4_addr0", RW'(wlog[0]), RW'(10'h3FE));
      chk("t4_addr1", RW'(wlog[1]), RW'(10'h3FF));
      chk("t4_addr2", RW'(wlog[2]), RW'(10'h000));
      chk("t4_addr3", RW'(wlog[3]), RW'(10'h001));
    end

    // Reset in the middle of draining with 2 rows still buffered.
    start_job(10'h050, 32);
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_row(rand_row());
    mem_ready = 1'b1;
    repeat (2) step();
    mem_ready = 1'b0;
    chk("t5_buffered", RW'(mem_we), RW'(1'b1));
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t5_we", RW'(mem_we), '0);
    chk("t5_busy", RW'(busy), '0);
    chk("t5_finish", RW'(finish), '0);
    chk("t5_rows_written", RW'(rows_written), '0);
    mem_ready = 1'b1;
    wlog.delete();
    start_job(10'h020, 16);
    push_row(rand_row());
    push_row(rand_row());
    wait_finish("t5_clean_finish");
    chk("t5_clean_nwrites", RW'(wlog.size()), RW'(2));
    if (wlog.size() == 2) begin
      chk("t5_clean_addr0", RW'(wlog[0]), RW'(10'h020));
      chk("t5_clean_addr1", RW'(wlog[1]), RW'(10'h021));
    end

`ifdef CONJ_WB_CHECKSUM_EN
    start_job(10'h000, 16);
    push_row(fill_row(64'h1));
    push_row(fill_row(64'h3));
    wait_finish("t6_finish");
    chk("t6_checksum_cancel", RW'(row_checksum), '0);
    start_job(10'h000, 8);
    r = '0;
    r[EW-1:0] = 64'hA5;
    push_row(r);
    wait_finish("t6b_finish");
    chk("t6_checksum_a5", RW'(row_checksum), RW'(64'hA5));
`else
    r = fill_row(64'h0);
`endif

    // Randomized traffic checked every cycle by the model.
    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(0, 299) == 0);
      start     = ($urandom_range(0, 14) == 0);
      base_addr = AW'($urandom);
      total     = $urandom_range(0, 80);
      in_valid  = ($urandom_range(0, 2) != 0);
      in_data   = rand_row();
      mem_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    reset = 1'b0; start = 1'b0; in_valid = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
